// File: rtl/ram_arbiter.sv
// Round-robin arbiter: NUM_REQ requesters share one single-port synchronous RAM.
// Latency: grant on the first edge seeing req, done pulses in the cycle after the third edge; 1 access / 3 cycles.
// Backpressure: requests are level-held until done; losers simply wait, and their inputs are ignored.
module ram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_wren,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic [ADDR_WIDTH-1:0]            ram_address,
    output logic [DATA_WIDTH-1:0]            ram_data,
    output logic                             ram_wren,
    input  logic [DATA_WIDTH-1:0]            ram_q
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    state_t                  state_q,       state_d;
    logic [IDX_W-1:0]        last_q,        last_d;
    logic [IDX_W-1:0]        owner_q,       owner_d;
    logic                    op_wr_q,       op_wr_d;
    logic [NUM_REQ-1:0]      gnt_q,         gnt_d;
    logic [NUM_REQ-1:0]      done_q,        done_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,     rd_data_d;
    logic [ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0]   ram_data_q,    ram_data_d;
    logic                    ram_wren_q,    ram_wren_d;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;

    // Search starts just past the previous winner and wraps, so every requester
    // is reached within NUM_REQ grants.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(last_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        op_wr_d       = op_wr_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        rd_data_d     = rd_data_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = ram_wren_q;

        case (state_q)
            IDLE: begin
                ram_wren_d = 1'b0;
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    last_d         = win_idx;
                    op_wr_d        = req_wren[win_idx];
                    ram_wren_d     = req_wren[win_idx];
                    ram_address_d  = req_address[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_data_d     = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    state_d        = ACCESS;
                end
            end
            ACCESS: begin
                // RAM samples address/wren on this edge; drop the strobe so a
                // write lasts exactly one cycle.
                ram_wren_d = 1'b0;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                if (!op_wr_q) begin
                    rd_data_d = ram_q;
                end
                done_d[owner_q] = 1'b1;
                gnt_d           = '0;
                state_d         = IDLE;
            end
            default: begin
                gnt_d      = '0;
                ram_wren_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= LAST_RST;
            owner_q       <= '0;
            op_wr_q       <= 1'b0;
            gnt_q         <= '0;
            done_q        <= '0;
            rd_data_q     <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            op_wr_q       <= op_wr_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rd_data_q     <= rd_data_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rd_data     = rd_data_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(done));
    a_done_no_gnt: assert property (@(posedge clk) disable iff (reset) !((|done) && (|gnt)));
    a_wren_owned: assert property (@(posedge clk) disable iff (reset) ram_wren |-> (|gnt));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port synchronous RAM.
module tb_ram_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_wren;
    logic [NR*AW-1:0]  req_address;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rd_data;
    logic [AW-1:0]     ram_address;
    logic [DW-1:0]     ram_data;
    logic              ram_wren;
    logic [DW-1:0]     ram_q = '0;

    bit [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk  = 0;
    int n_fail = 0;

    ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_wren    (req_wren),
        .req_address (req_address),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .rd_data     (rd_data),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    typedef struct {
        int          idx;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input bit wr, input logic [15:0] addr, input logic [15:0] data);
        req_wren[idx]           = wr;
        req_address[idx*AW +: AW] = addr;
        req_data[idx*DW +: DW]    = data;
    endtask

    // One full access for a lone requester: grant, access, done, idle.
    task automatic run_vec(input vec_t v);
        logic [NR-1:0] oh;
        oh = '0;
        oh[v.idx] = 1'b1;
        set_req(v.idx, v.wr, v.addr, v.data);
        req = oh;
        tick();
        chk("grant", 32'(gnt), 32'(oh));
        chk("grant_addr", 32'(ram_address), 32'(v.addr));
        chk("grant_wren", 32'(ram_wren), 32'(v.wr));
        if (v.wr) chk("grant_data", 32'(ram_data), 32'(v.data));
        tick();
        chk("access_wren_clear", 32'(ram_wren), 32'd0);
        chk("access_gnt", 32'(gnt), 32'(oh));
        chk("access_no_done", 32'(done), 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'(oh));
        chk("done_gnt_clear", 32'(gnt), 32'd0);
        chk("rd_data", 32'(rd_data), 32'(v.exp_rd));
        req = '0;
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000};
        vecs[1] = '{0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        vecs[2] = '{3, 1'b1, 16'h00A0, 16'h5A5A, 16'hBEEF};
        vecs[3] = '{1, 1'b0, 16'h00A0, 16'h0000, 16'h5A5A};
        vecs[4] = '{2, 1'b1, 16'h0010, 16'h1234, 16'h5A5A};
        vecs[5] = '{2, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[6] = '{1, 1'b1, 16'hFFFF, 16'h0001, 16'h1234};
        vecs[7] = '{3, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};
        vecs[8] = '{2, 1'b0, 16'h0000, 16'h0000, 16'h0000};

        reset = 1'b1;
        req = '0; req_wren = '0; req_address = '0; req_data = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        chk("rst_ram_data", 32'(ram_data), 32'd0);
        chk("rst_ram_wren", 32'(ram_wren), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Fairness: all four held, last winner reset to 3.
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 16'h0100 + 16'(i), 16'h0000);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair_gnt", 32'(gnt), 32'(1) << (k % 4));
            tick();
            tick();
            chk("fair_done", 32'(done), 32'(1) << (k % 4));
        end
        req = '0;
        tick();

        // Rotation skip: winner 1, then 1001 gives 3 then 0.
        do_reset();
        set_req(1, 1'b0, 16'h0001, 16'h0000);
        set_req(0, 1'b0, 16'h0002, 16'h0000);
        set_req(3, 1'b0, 16'h0003, 16'h0000);
        req = 4'b0010;
        tick();
        chk("rot_first", 32'(gnt), 32'h2);
        tick();
        tick();
        req = 4'b1001;
        tick();
        chk("rot_skip_to_3", 32'(gnt), 32'h8);
        tick();
        tick();
        tick();
        chk("rot_wrap_to_0", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();
        tick();

        // Withdraw during ACCESS: access still completes.
        set_req(2, 1'b0, 16'h0010, 16'h0000);
        req = 4'b0100;
        tick();
        chk("wd_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
        tick();
        chk("wd_done", 32'(done), 32'h4);
        chk("wd_rd_data", 32'(rd_data), 32'h1234);
        tick();

        // Reset while a write is in ACCESS: aborted, RAM untouched.
        set_req(0, 1'b1, 16'h0005, 16'h7777);
        req = 4'b0001;
        tick();
        chk("rstw_wren_before", 32'(ram_wren), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw_gnt", 32'(gnt), 32'd0);
        chk("rstw_wren", 32'(ram_wren), 32'd0);
        req = '0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstw_no_done", 32'(done), 32'd0);
        end
        chk("rstw_mem", 32'(mem[16'h0005]), 32'hBEEF);
        run_vec('{0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF});

        // Isolation: loser's and owner's inputs change after the grant edge.
        do_reset();
        set_req(0, 1'b1, 16'h0020, 16'h1111);
        set_req(1, 1'b1, 16'h0030, 16'h2222);
        req = 4'b0011;
        tick();
        chk("iso_gnt0", 32'(gnt), 32'h1);
        chk("iso_addr0", 32'(ram_address), 32'h0020);
        chk("iso_data0", 32'(ram_data), 32'h1111);
        set_req(1, 1'b1, 16'h0031, 16'h3333);
        set_req(0, 1'b1, 16'h0099, 16'h9999);
        tick();
        chk("iso_addr_hold", 32'(ram_address), 32'h0020);
        chk("iso_data_hold", 32'(ram_data), 32'h1111);
        req = 4'b0010;
        tick();
        chk("iso_done0", 32'(done), 32'h1);
        tick();
        chk("iso_gnt1", 32'(gnt), 32'h2);
        chk("iso_addr1", 32'(ram_address), 32'h0031);
        chk("iso_data1", 32'(ram_data), 32'h3333);
        req = '0;
        tick();
        tick();
        chk("iso_done1", 32'(done), 32'h2);
        chk("iso_mem20", 32'(mem[16'h0020]), 32'h1111);
        chk("iso_mem30", 32'(mem[16'h0030]), 32'h0000);
        chk("iso_mem31", 32'(mem[16'h0031]), 32'h3333);
        chk("iso_mem99", 32'(mem[16'h0099]), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the one-port RAM.
REQ-002 Parameter ADDR_WIDTH, default 16, RAM word-address width.
REQ-003 Parameter DATA_WIDTH, default 16, RAM word width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester access request, level, held until done.
REQ-007 req_wren  input  NUM_REQ  per-requester write (1) / read (0) select.
REQ-008 req_address  input  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
REQ-010 gnt  output  NUM_REQ  one-hot grant, high while the owner's access is in flight.
REQ-011 done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-012 rd_data  output  DATA_WIDTH  read result, valid in the done cycle, held until next read completes.
REQ-013 ram_address  output  ADDR_WIDTH  registered RAM address.
REQ-014 ram_data  output  DATA_WIDTH  registered RAM write data.
REQ-015 ram_wren  output  1  registered RAM write enable.
REQ-016 ram_q  input  DATA_WIDTH  RAM read data, valid one clock after the address edge.

Function
REQ-017 FSM states: IDLE, ACCESS, CAPTURE; reset state IDLE.
REQ-018 IDLE with req != 0: select winner, set gnt one-hot, load ram_address/ram_data/ram_wren from winner, go ACCESS; IDLE with req == 0: stay, ram_wren 0.
REQ-019 Winner: round-robin; search starts at index (last_winner+1) mod NUM_REQ, ascending with wrap; last_winner resets to NUM_REQ-1 so requester 0 has first priority.
REQ-020 last_winner updates only on the IDLE->ACCESS edge.
REQ-021 ACCESS: always one cycle; RAM samples address on exit edge; ram_wren cleared on that edge; go CAPTURE.
REQ-022 CAPTURE: for reads, rd_data <= ram_q on exit edge; for writes rd_data unchanged; assert done[winner] for exactly the following cycle; clear gnt; go IDLE.
REQ-023 Latency: req seen in IDLE at edge N -> done high during cycle after edge N+2; new grant earliest at edge N+3; throughput one access per 3 cycles.
REQ-024 ram_wren high for exactly one cycle per write, never for reads.
REQ-025 Inputs of non-granted requesters ignored; winner's req_address/req_data/req_wren sampled only at the grant edge.
REQ-026 req withdrawn after grant: access completes, done still pulses.
REQ-027 req still high in the done cycle: treated as a new request (arbitrated normally in IDLE).
REQ-028 gnt and done each at most one bit set; done never set while gnt set.

Reset
REQ-029 reset asserted: immediately state IDLE, gnt 0, done 0, ram_wren 0, ram_address 0, ram_data 0, rd_data 0, last_winner NUM_REQ-1.
REQ-030 reset mid-access aborts the transaction: no done pulse, no write if ram_wren had not yet been sampled.
REQ-031 After reset deassertion, first arbitration on the first rising edge with req != 0.

Verification
REQ-032 Single write then read: req0 write addr 0x0005 data 0xBEEF; then read 0x0005 -> ram_wren one cycle, done[0] 3 cycles after req, rd_data 0xBEEF.
REQ-033 Fairness: req = 4'b1111 held continuously, each re-requesting -> grant order 0,1,2,3,0,1 and one done every 3 cycles.
REQ-034 Rotation skip: last winner 1, req = 4'b1001 -> grant 3, then 0.
REQ-035 Withdraw: req2 read of 0x0010 (RAM holds 0x1234), req2 dropped in ACCESS -> done[2] still pulses, rd_data 0x1234.
REQ-036 Reset mid-write: reset asserted during ACCESS -> gnt 0, ram_wren 0 at once, no done; following read of that address returns prior contents.
REQ-037 Isolation: requester 1 changes req_address/req_data while requester 0 is granted -> ram_address/ram_data reflect requester 0 only.
